// File: rtl/ultrasound_pkg.sv
// ultrasound_pkg
// Shared definitions for the multi-echo ultrasound acquisition sequencer.
// Holds the state encoding, the state enum built on that encoding, and the
// TX firing-mode constants used to decode the TX_MODE input.
package ultrasound_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ADC_ST = 3'd1;
  localparam logic [2:0] ST_TX     = 3'd2;
  localparam logic [2:0] ST_DELAY  = 3'd3;
  localparam logic [2:0] ST_ACQ    = 3'd4;
  localparam logic [2:0] ST_GAP    = 3'd5;
  localparam logic [2:0] ST_DONE   = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_ADC_ST = ST_ADC_ST,
    S_TX     = ST_TX,
    S_DELAY  = ST_DELAY,
    S_ACQ    = ST_ACQ,
    S_GAP    = ST_GAP,
    S_DONE   = ST_DONE
  } state_t;

  localparam logic TX_MODE_ALL = 1'b0;
  localparam logic TX_MODE_RR  = 1'b1;

endpackage

// File: rtl/us_rr_chan_sel.sv
// us_rr_chan_sel
// Combinational round-robin channel picker. Given the allowed-channel mask
// and the currently selected one-hot channel, returns the next set mask bit
// above the current one, wrapping to the lowest. An all-zero current
// selection yields the lowest set mask bit; an all-zero mask yields zero.
// Ports:
//   mask      in   NUM_CH  channels allowed to fire
//   cur_sel   in   NUM_CH  current one-hot selection (or zero)
//   next_sel  out  NUM_CH  next one-hot selection (or zero)
module us_rr_chan_sel
  import ultrasound_pkg::*;
#(
  parameter int NUM_CH = 4
) (
  input  logic [NUM_CH-1:0] mask,
  input  logic [NUM_CH-1:0] cur_sel,
  output logic [NUM_CH-1:0] next_sel
);

  int   cur_pos;
  int   idx;
  logic found;

  // Locate the current channel, then scan upward from the position after it
  // with wrap. Starting from the top position when nothing is selected makes
  // the scan begin at bit 0, which gives the lowest set bit for echo 0.
  always_comb begin
    cur_pos  = NUM_CH - 1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cur_sel[i]) begin
        cur_pos = i;
      end
    end
    next_sel = '0;
    found    = 1'b0;
    idx      = 0;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = (cur_pos + k) % NUM_CH;
      if (!found && mask[idx]) begin
        next_sel[idx] = 1'b1;
        found         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ultrasound_multi_echo_seq.sv
// ultrasound_multi_echo_seq
// Multi-echo, multi-channel ultrasound acquisition sequencer. A rising edge
// on START (while idle) runs one ADC start pulse followed by ECHO_COUNT
// echoes of TX burst / init delay / acquisition window, with a gap between
// echoes. A single shared down-counter times every state.
// Ports:
//   CLK, RESET_N          clock and synchronous active-low reset
//   START, ABORT          launch request (edge) and abort (priority)
//   ADC_START_length, TX_PULSE_LEN, ADC_INIT_DELAY,
//   ADC_SAMPLES_PER_ECHO, ECHO_GAP     per-state lengths in cycles
//   ECHO_COUNT            echoes per sequence (0 treated as 1)
//   TX_CH_MASK, TX_MODE   allowed channels, all-fire or round-robin
//   TX_EN, ADC_START, FIFO_EN          registered drive outputs
//   BUSY, DONE, ECHO_IDX  registered status outputs
module ultrasound_multi_echo_seq
  import ultrasound_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int CNT_WIDTH  = 32,
  parameter int ECHO_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  START,
  input  logic                  ABORT,
  input  logic [CNT_WIDTH-1:0]  ADC_START_length,
  input  logic [CNT_WIDTH-1:0]  TX_PULSE_LEN,
  input  logic [CNT_WIDTH-1:0]  ADC_INIT_DELAY,
  input  logic [CNT_WIDTH-1:0]  ADC_SAMPLES_PER_ECHO,
  input  logic [CNT_WIDTH-1:0]  ECHO_GAP,
  input  logic [ECHO_WIDTH-1:0] ECHO_COUNT,
  input  logic [NUM_CH-1:0]     TX_CH_MASK,
  input  logic                  TX_MODE,
  output logic [NUM_CH-1:0]     TX_EN,
  output logic                  ADC_START,
  output logic                  FIFO_EN,
  output logic                  BUSY,
  output logic                  DONE,
  output logic [ECHO_WIDTH-1:0] ECHO_IDX
);

  state_t                state;
  state_t                next_state;
  logic                  start_q;
  logic                  start_prev;
  logic                  launch_go;
  logic                  cnt_zero;
  logic                  last_echo;
  logic [CNT_WIDTH-1:0]  cnt;
  logic [CNT_WIDTH-1:0]  cnt_load;
  logic [CNT_WIDTH-1:0]  lat_tx;
  logic [CNT_WIDTH-1:0]  lat_delay;
  logic [CNT_WIDTH-1:0]  lat_samples;
  logic [CNT_WIDTH-1:0]  lat_gap;
  logic [ECHO_WIDTH-1:0] lat_last_idx;
  logic [ECHO_WIDTH-1:0] echo_idx;
  logic [NUM_CH-1:0]     lat_mask;
  logic                  lat_mode;
  logic [NUM_CH-1:0]     rr_sel;
  logic [NUM_CH-1:0]     sel_mask;
  logic [NUM_CH-1:0]     sel_cur;
  logic [NUM_CH-1:0]     sel_next;
  logic [NUM_CH-1:0]     tx_en_d;
  logic                  adc_d;
  logic                  fifo_d;
  logic                  busy_d;
  logic                  done_d;

  // A programmed length L lasts max(L,1) cycles, so the counter load is
  // max(L,1)-1 and the state ends when the counter reads zero.
  function automatic logic [CNT_WIDTH-1:0] load_of(input logic [CNT_WIDTH-1:0] len);
    return (len == '0) ? '0 : len - CNT_WIDTH'(1);
  endfunction

  assign cnt_zero  = (cnt == '0);
  assign last_echo = (echo_idx == lat_last_idx);
  assign launch_go = (state == S_IDLE) && (next_state == S_ADC_ST);
  assign ECHO_IDX  = echo_idx;

  // START is registered once; the previous registered value lets us see a
  // clean rising edge, so holding START high never relaunches by itself.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      start_q    <= 1'b0;
      start_prev <= 1'b0;
    end else begin
      start_q    <= START;
      start_prev <= start_q;
    end
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. ABORT overrides everything, including a launch in the
  // same cycle. After the last acquisition window we go straight to DONE,
  // so there is never a trailing gap.
  always_comb begin
    next_state = state;
    if (ABORT) begin
      next_state = S_IDLE;
    end else begin
      case (state)
        S_IDLE:   if (start_q && !start_prev) next_state = S_ADC_ST;
        S_ADC_ST: if (cnt_zero) next_state = S_TX;
        S_TX:     if (cnt_zero) next_state = S_DELAY;
        S_DELAY:  if (cnt_zero) next_state = S_ACQ;
        S_ACQ:    if (cnt_zero) next_state = last_echo ? S_DONE : S_GAP;
        S_GAP:    if (cnt_zero) next_state = S_TX;
        S_DONE:   if (!start_q) next_state = S_IDLE;
        default:  next_state = S_IDLE;
      endcase
    end
  end

  // Pick the counter load for whichever state we are about to enter. The
  // ADC start length is taken straight from the input because the latched
  // copies only become valid on the launch edge itself.
  always_comb begin
    cnt_load = '0;
    case (next_state)
      S_ADC_ST: cnt_load = load_of(ADC_START_length);
      S_TX:     cnt_load = load_of(lat_tx);
      S_DELAY:  cnt_load = load_of(lat_delay);
      S_ACQ:    cnt_load = load_of(lat_samples);
      S_GAP:    cnt_load = load_of(lat_gap);
      default:  cnt_load = '0;
    endcase
  end

  // Shared down-counter: reloaded on every state change, otherwise counts
  // down and parks at zero rather than wrapping.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      cnt <= '0;
    end else if (next_state != state) begin
      cnt <= cnt_load;
    end else if (!cnt_zero) begin
      cnt <= cnt - CNT_WIDTH'(1);
    end
  end

  // The channel picker is shared: at launch it finds the lowest set bit of
  // the incoming mask, later it steps through the latched mask.
  assign sel_mask = launch_go ? TX_CH_MASK : lat_mask;
  assign sel_cur  = launch_go ? '0 : rr_sel;

  us_rr_chan_sel #(
    .NUM_CH (NUM_CH)
  ) u_rr_chan_sel (
    .mask     (sel_mask),
    .cur_sel  (sel_cur),
    .next_sel (sel_next)
  );

  // Sequence context: everything is captured on launch so later input
  // changes cannot disturb a running sequence. The round-robin channel is
  // advanced on entry to GAP so it is already settled when the next TX
  // starts; the echo index steps on GAP exit and survives ABORT.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      lat_tx       <= '0;
      lat_delay    <= '0;
      lat_samples  <= '0;
      lat_gap      <= '0;
      lat_last_idx <= '0;
      lat_mask     <= '0;
      lat_mode     <= 1'b0;
      rr_sel       <= '0;
      echo_idx     <= '0;
    end else if (launch_go) begin
      lat_tx       <= TX_PULSE_LEN;
      lat_delay    <= ADC_INIT_DELAY;
      lat_samples  <= ADC_SAMPLES_PER_ECHO;
      lat_gap      <= ECHO_GAP;
      lat_last_idx <= (ECHO_COUNT == '0) ? '0 : ECHO_COUNT - ECHO_WIDTH'(1);
      lat_mask     <= TX_CH_MASK;
      lat_mode     <= TX_MODE;
      rr_sel       <= sel_next;
      echo_idx     <= '0;
    end else begin
      if (state == S_ACQ && next_state == S_GAP) begin
        rr_sel <= sel_next;
      end
      if (state == S_GAP && next_state == S_TX) begin
        echo_idx <= echo_idx + ECHO_WIDTH'(1);
      end
    end
  end

  // Output decode from the state being entered, so the registered outputs
  // line up exactly with the registered state.
  always_comb begin
    tx_en_d = '0;
    adc_d   = 1'b0;
    fifo_d  = 1'b0;
    done_d  = 1'b0;
    case (next_state)
      S_ADC_ST: adc_d = 1'b1;
      S_TX: begin
        case (lat_mode)
          TX_MODE_ALL: tx_en_d = lat_mask;
          TX_MODE_RR:  tx_en_d = rr_sel;
          default:     tx_en_d = '0;
        endcase
      end
      S_ACQ:    fifo_d = 1'b1;
      S_DONE:   done_d = 1'b1;
      default:  tx_en_d = '0;
    endcase
    busy_d = (next_state != S_IDLE) && (next_state != S_DONE);
  end

  // Output registers.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      TX_EN     <= '0;
      ADC_START <= 1'b0;
      FIFO_EN   <= 1'b0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
    end else begin
      TX_EN     <= tx_en_d;
      ADC_START <= adc_d;
      FIFO_EN   <= fifo_d;
      BUSY      <= busy_d;
      DONE      <= done_d;
    end
  end

endmodule

// File: tb/tb_ultrasound_multi_echo_seq.sv
// tb_ultrasound_multi_echo_seq
// Scoreboard bench for the multi-echo sequencer. Each test pushes the
// expected output segments (constant output vector + run length) into a
// queue before launching; a monitor run-length encodes the DUT outputs on
// every falling edge and pops/compares each completed active segment.
module tb_ultrasound_multi_echo_seq;

  typedef struct {
    logic [3:0] tx;
    logic       adc;
    logic       fifo;
    logic       busy;
    logic       done;
    logic [7:0] idx;
    int         len;
  } seg_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        abort;
  logic [31:0] adc_start_length;
  logic [31:0] tx_pulse_len;
  logic [31:0] adc_init_delay;
  logic [31:0] adc_samples;
  logic [31:0] echo_gap;
  logic [7:0]  echo_count;
  logic [3:0]  tx_ch_mask;
  logic        tx_mode;
  logic [3:0]  tx_en;
  logic        adc_start;
  logic        fifo_en;
  logic        busy;
  logic        done;
  logic [7:0]  echo_idx;

  seg_t exp_q[$];
  seg_t cur;
  int   run_len = 0;
  int   seg_no = 0;
  int   checks = 0;
  int   failures = 0;
  logic mon_en = 1'b0;

  ultrasound_multi_echo_seq #(
    .NUM_CH     (4),
    .CNT_WIDTH  (32),
    .ECHO_WIDTH (8)
  ) dut (
    .CLK                  (clk),
    .RESET_N              (reset_n),
    .START                (start),
    .ABORT                (abort),
    .ADC_START_length     (adc_start_length),
    .TX_PULSE_LEN         (tx_pulse_len),
    .ADC_INIT_DELAY       (adc_init_delay),
    .ADC_SAMPLES_PER_ECHO (adc_samples),
    .ECHO_GAP             (echo_gap),
    .ECHO_COUNT           (echo_count),
    .TX_CH_MASK           (tx_ch_mask),
    .TX_MODE              (tx_mode),
    .TX_EN                (tx_en),
    .ADC_START            (adc_start),
    .FIFO_EN              (fifo_en),
    .BUSY                 (busy),
    .DONE                 (done),
    .ECHO_IDX             (echo_idx)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  function automatic int eff(input int l);
    return (l == 0) ? 1 : l;
  endfunction

  function automatic logic same_vec(input seg_t a, input seg_t b);
    return (a.tx == b.tx) && (a.adc == b.adc) && (a.fifo == b.fifo) &&
           (a.busy == b.busy) && (a.done == b.done) && (a.idx == b.idx);
  endfunction

  // Queue one expected segment; adjacent identical vectors (e.g. TX with an
  // empty mask followed by DELAY) are seen as one run, so merge them.
  task automatic push_seg(input logic [3:0] tx, input logic adc, input logic fifo,
                          input logic bsy, input logic dn, input logic [7:0] idx,
                          input int len);
    seg_t s;
    seg_t p;
    s.tx = tx; s.adc = adc; s.fifo = fifo; s.busy = bsy; s.done = dn;
    s.idx = idx; s.len = len;
    if (exp_q.size() > 0) begin
      p = exp_q[exp_q.size()-1];
      if (same_vec(p, s) && p.len != 0 && s.len != 0) begin
        p = exp_q.pop_back();
        s.len = p.len + s.len;
      end
    end
    exp_q.push_back(s);
  endtask

  // Compare one completed segment against the scoreboard; quiet (idle)
  // runs carry no expectation.
  task automatic close_seg(input seg_t got);
    seg_t e;
    if (got.tx == 4'b0 && !got.adc && !got.fifo && !got.busy && !got.done) return;
    seg_no++;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("[TB] FAIL unexpected_seg%0d got tx=%b adc=%b fifo=%b busy=%b done=%b idx=%0d len=%0d",
               seg_no, got.tx, got.adc, got.fifo, got.busy, got.done, got.idx, got.len);
      return;
    end
    e = exp_q.pop_front();
    if (!same_vec(got, e) || (e.len != 0 && e.len != got.len)) begin
      failures++;
      $display("[TB] FAIL seg%0d got tx=%b adc=%b fifo=%b busy=%b done=%b idx=%0d len=%0d exp tx=%b adc=%b fifo=%b busy=%b done=%b idx=%0d len=%0d",
               seg_no, got.tx, got.adc, got.fifo, got.busy, got.done, got.idx, got.len,
               e.tx, e.adc, e.fifo, e.busy, e.done, e.idx, e.len);
    end
  endtask

  // Monitor: run-length encode the outputs on the falling edge and hand
  // each finished run to the scoreboard.
  always @(negedge clk) begin : monitor_proc
    seg_t s;
    if (mon_en) begin
      s.tx = tx_en; s.adc = adc_start; s.fifo = fifo_en; s.busy = busy;
      s.done = done; s.idx = echo_idx; s.len = 1;
      if (run_len == 0) begin
        cur = s;
        run_len = 1;
      end else if (same_vec(s, cur)) begin
        run_len++;
      end else begin
        cur.len = run_len;
        close_seg(cur);
        cur = s;
        run_len = 1;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [3:0] e_tx, input logic e_adc,
                             input logic e_fifo, input logic e_busy, input logic e_done,
                             input logic [7:0] e_idx, input logic use_idx);
    checks++;
    if (tx_en !== e_tx || adc_start !== e_adc || fifo_en !== e_fifo || busy !== e_busy ||
        done !== e_done || (use_idx && echo_idx !== e_idx)) begin
      failures++;
      $display("[TB] FAIL %s got tx=%b adc=%b fifo=%b busy=%b done=%b idx=%0d exp tx=%b adc=%b fifo=%b busy=%b done=%b idx=%0d",
               name, tx_en, adc_start, fifo_en, busy, done, echo_idx,
               e_tx, e_adc, e_fifo, e_busy, e_done, e_idx);
    end
  endtask

  // Bounded wait for a DUT condition: 0 DONE, 1 second-echo ACQ,
  // 2 second-echo TX, 3 first DELAY cycle.
  task automatic waitFor(input int which, input string name);
    int   n;
    logic hit;
    n = 0;
    hit = 1'b0;
    while (!hit && n < 3000) begin
      @(negedge clk);
      n++;
      case (which)
        0:       hit = done;
        1:       hit = fifo_en && echo_idx == 8'd1;
        2:       hit = (tx_en != 4'b0) && echo_idx == 8'd1;
        default: hit = busy && !adc_start && !fifo_en && tx_en == 4'b0;
      endcase
    end
    checks++;
    if (!hit) begin
      failures++;
      $display("[TB] FAIL timeout_%s got waited=%0d cycles required event", name, n);
    end
  endtask

  task automatic set_inputs(input int adc_len, input int tx_len, input int dly, input int smp,
                            input int gap, input int n, input logic [3:0] mask, input logic mode);
    adc_start_length = 32'(adc_len);
    tx_pulse_len     = 32'(tx_len);
    adc_init_delay   = 32'(dly);
    adc_samples      = 32'(smp);
    echo_gap         = 32'(gap);
    echo_count       = 8'(n);
    tx_ch_mask       = mask;
    tx_mode          = mode;
  endtask

  // Full run: queue expected segments, launch, optionally disturb inputs
  // during the first DELAY, then check DONE holding and the return to idle.
  // tx_seq holds the hand-computed TX_EN per echo, echo 0 in the low nibble.
  task automatic applyStimulus(input string name, input int adc_len, input int tx_len,
                               input int dly, input int smp, input int gap, input int n,
                               input logic [3:0] mask, input logic mode,
                               input logic [31:0] tx_seq, input logic mutate);
    int ne;
    $display("[TB] test %s", name);
    ne = (n == 0) ? 1 : n;
    push_seg(4'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0, eff(adc_len));
    for (int e = 0; e < ne; e++) begin
      push_seg(tx_seq[e*4 +: 4], 1'b0, 1'b0, 1'b1, 1'b0, 8'(e), eff(tx_len));
      push_seg(4'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'(e), eff(dly));
      push_seg(4'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'(e), eff(smp));
      if (e < ne - 1) push_seg(4'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'(e), eff(gap));
    end
    push_seg(4'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'(ne - 1), 0);
    set_inputs(adc_len, tx_len, dly, smp, gap, n, mask, mode);
    start = 1'b1;
    if (mutate) begin
      waitFor(3, "first_delay");
      adc_samples = 32'd20;
      tx_ch_mask  = 4'hF;
      echo_count  = 8'd5;
    end
    waitFor(0, "done");
    repeat (3) @(negedge clk);
    checkOutput({name, "_done_hold"}, 4'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'(ne - 1), 1'b1);
    start = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput({name, "_idle"}, 4'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'(ne - 1), 1'b1);
  endtask

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    abort   = 1'b0;
    set_inputs(0, 0, 0, 0, 0, 0, 4'b0, 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("reset_state", 4'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1);
    reset_n = 1'b1;
    mon_en  = 1'b1;
    @(negedge clk);

    applyStimulus("base", 5, 3, 10, 10, 4, 2, 4'b0101, 1'b0, 32'h0000_0055, 1'b0);
    applyStimulus("round_robin", 2, 2, 1, 2, 1, 4, 4'b1011, 1'b1, 32'h0000_1821, 1'b0);
    applyStimulus("zero_len", 0, 0, 0, 0, 0, 0, 4'b0011, 1'b0, 32'h0000_0003, 1'b0);
    applyStimulus("mask_zero", 1, 2, 1, 1, 1, 2, 4'b0000, 1'b1, 32'h0000_0000, 1'b0);
    applyStimulus("input_change", 3, 2, 4, 10, 2, 2, 4'b1100, 1'b0, 32'h0000_00CC, 1'b1);

    $display("[TB] test abort");
    push_seg(4'b0,    1'b1, 1'b0, 1'b1, 1'b0, 8'd0, 2);
    push_seg(4'b0011, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 2);
    push_seg(4'b0,    1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 2);
    push_seg(4'b0,    1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 6);
    push_seg(4'b0,    1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 2);
    push_seg(4'b0011, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1, 2);
    push_seg(4'b0,    1'b0, 1'b0, 1'b1, 1'b0, 8'd1, 2);
    push_seg(4'b0,    1'b0, 1'b1, 1'b1, 1'b0, 8'd1, 3);
    set_inputs(2, 2, 2, 6, 2, 3, 4'b0011, 1'b0);
    start = 1'b1;
    waitFor(1, "second_acq");
    repeat (2) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("abort_drop", 4'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
    repeat (10) @(negedge clk);
    checkOutput("abort_no_relaunch", 4'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
    start = 1'b0;
    repeat (3) @(negedge clk);

    $display("[TB] test abort_at_launch");
    set_inputs(1, 1, 1, 1, 1, 1, 4'b0001, 1'b0);
    start = 1'b1;
    abort = 1'b1;
    repeat (3) @(negedge clk);
    abort = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("abort_at_launch", 4'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
    start = 1'b0;
    repeat (3) @(negedge clk);

    $display("[TB] test reset_mid_tx");
    push_seg(4'b0,    1'b1, 1'b0, 1'b1, 1'b0, 8'd0, 1);
    push_seg(4'b0010, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 4);
    push_seg(4'b0,    1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 1);
    push_seg(4'b0,    1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 1);
    push_seg(4'b0,    1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 1);
    push_seg(4'b0100, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1, 3);
    set_inputs(1, 4, 1, 1, 1, 2, 4'b0110, 1'b1);
    start = 1'b1;
    waitFor(2, "second_tx");
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    start   = 1'b0;
    @(negedge clk);
    checkOutput("reset_mid_tx", 4'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    applyStimulus("after_reset", 1, 4, 1, 1, 1, 2, 4'b0110, 1'b1, 32'h0000_0042, 1'b0);

    repeat (5) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_drain got %0d pending segments required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
